// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, one-hot
// Load/Store bit positions and byte-strobe patterns.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } lsu_state_e;

  localparam int LD_LB  = 0;
  localparam int LD_LH  = 1;
  localparam int LD_LW  = 2;
  localparam int LD_LBU = 3;
  localparam int LD_LHU = 4;

  localparam int ST_SB = 0;
  localparam int ST_SH = 1;
  localparam int ST_SW = 2;

  localparam logic [3:0] WSTRB_NONE    = 4'b0000;
  localparam logic [3:0] WSTRB_BYTE0   = 4'b0001;
  localparam logic [3:0] WSTRB_LO_HALF = 4'b0011;
  localparam logic [3:0] WSTRB_HI_HALF = 4'b1100;
  localparam logic [3:0] WSTRB_ALL     = 4'b1111;

  // True when more than one bit of v is set.
  function automatic logic multi_hot(input logic [4:0] v);
    return (v & (v - 5'd1)) != 5'd0;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Memory-side bus of the load/store unit.
// Handshake: mem_req stays high with addr/we/wstrb/wdata stable until the
// memory raises mem_ack (possibly in the first req cycle); mem_rdata is valid
// only while mem_ack is high. mem_ack while mem_req is low is ignored.
interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-strobe/data replication and load
// byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [4:0]  load_type,
  input  logic [2:0]  store_type,
  input  logic [1:0]  byte_off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_fmt,
  output logic [31:0] rdata_ext
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wstrb     = WSTRB_NONE;
    wdata_fmt = st_data;
    if (store_type[ST_SB]) begin
      wstrb     = WSTRB_BYTE0 << byte_off;
      wdata_fmt = {4{st_data[7:0]}};
    end else if (store_type[ST_SH]) begin
      wstrb     = byte_off[1] ? WSTRB_HI_HALF : WSTRB_LO_HALF;
      wdata_fmt = {2{st_data[15:0]}};
    end else if (store_type[ST_SW]) begin
      wstrb     = WSTRB_ALL;
    end
  end

  always_comb begin
    ld_byte = ld_word[7:0];
    case (byte_off)
      2'd0: ld_byte = ld_word[7:0];
      2'd1: ld_byte = ld_word[15:8];
      2'd2: ld_byte = ld_word[23:16];
      2'd3: ld_byte = ld_word[31:24];
      default: ld_byte = ld_word[7:0];
    endcase
    ld_half = byte_off[1] ? ld_word[31:16] : ld_word[15:0];
  end

  always_comb begin
    rdata_ext = 32'd0;
    if (load_type[LD_LB])       rdata_ext = {{24{ld_byte[7]}}, ld_byte};
    else if (load_type[LD_LBU]) rdata_ext = {24'd0, ld_byte};
    else if (load_type[LD_LH])  rdata_ext = {{16{ld_half[15]}}, ld_half};
    else if (load_type[LD_LHU]) rdata_ext = {16'd0, ld_half};
    else if (load_type[LD_LW])  rdata_ext = ld_word;
  end

endmodule

// File: rtl/lsu_controller.sv
// Load/store unit FSM: checks and latches one access in IDLE, runs the memory
// handshake, and pulses done or err. Optional REQ watchdog: LSU_TIMEOUT_EN.
module lsu_controller
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Load,
  input  logic [2:0]  Store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output lsu_state_e  state_dbg,
  lsu_if.master       mem
);

  lsu_state_e  state_q, state_d;
  logic [4:0]  load_q, load_d;
  logic [2:0]  store_q, store_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        op_present, illegal, misaligned;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_rdata;
  logic        to_expired;

  assign op_present = (|Load) || (|Store);
  assign illegal    = multi_hot(Load) || multi_hot({2'b00, Store}) || ((|Load) && (|Store));
  assign misaligned = ((Load[LD_LW] || Store[ST_SW]) && (addr[1:0] != 2'b00)) ||
                      ((Load[LD_LH] || Load[LD_LHU] || Store[ST_SH]) && addr[0]);

  lsu_align u_align (
    .load_type  (load_q),
    .store_type (store_q),
    .byte_off   (addr_q[1:0]),
    .st_data    (wdata_q),
    .ld_word    (mem.mem_rdata),
    .wstrb      (al_wstrb),
    .wdata_fmt  (al_wdata),
    .rdata_ext  (al_rdata)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = '0;
    if (state_q == S_REQ) to_cnt_d = to_cnt_q + 1'b1;
  end

  // Expires on the last permitted REQ cycle, so mem_req is high for exactly TIMEOUT_CYCLES.
  assign to_expired = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end
`else
  assign to_expired = 1'b0;
  // REQ waits for mem_ack indefinitely; the parameter has no effect here.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d       = state_q;
    load_d        = load_q;
    store_d       = store_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    stall         = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    rdata         = 32'd0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_wstrb = WSTRB_NONE;
    mem.mem_wdata = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (op_present) begin
          stall = 1'b1;
          if (illegal || misaligned) begin
            state_d = S_ERR;
          end else begin
            state_d = S_REQ;
            load_d  = Load;
            store_d = Store;
            addr_d  = addr;
            wdata_d = wdata;
          end
        end
      end
      S_REQ: begin
        stall         = 1'b1;
        mem.mem_req   = 1'b1;
        mem.mem_we    = |store_q;
        mem.mem_wstrb = al_wstrb;
        mem.mem_wdata = (|store_q) ? al_wdata : 32'd0;
        if (mem.mem_ack) begin
          state_d = S_DONE;
          rdata_d = (|load_q) ? al_rdata : 32'd0;
        end else if (to_expired) begin
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        rdata   = rdata_q;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem.mem_addr = {addr_q[31:2], 2'b00};
  assign state_dbg    = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      load_q  <= 5'd0;
      store_q <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      store_q <= store_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Scoreboard bench for lsu_controller: directed accesses, memory responder,
// completion monitor. Timeout scenario runs when LSU_TIMEOUT_EN is defined.
module tb_lsu_controller;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  Load;
  logic [2:0]  Store;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  lsu_state_e  state_dbg;

  lsu_if mem_if ();

  lsu_controller #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .Load      (Load),
    .Store     (Store),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .state_dbg (state_dbg),
    .mem       (mem_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];      // {is_err, rdata}
  int          lat_q[$];      // cycle number the completion must land on
  logic [68:0] exp_mem_q[$];  // {we, addr, wstrb, wdata}

  int          ack_delay  = 0;
  bit          no_ack     = 1'b0;
  bit          force_ack  = 1'b0;
  logic [31:0] resp_rdata = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder + request monitor ----------------
  initial begin
    int   req_cycles;
    logic prev_req;
    logic [68:0] m;
    req_cycles = 0;
    prev_req   = 1'b0;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_if.mem_req === 1'b1) begin
        if (exp_mem_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_mem_req: got addr=%h want no request", mem_if.mem_addr);
        end else begin
          m = exp_mem_q[0];
          check("mem_we",    32'(mem_if.mem_we),    32'(m[68]));
          check("mem_addr",  mem_if.mem_addr,       m[67:36]);
          check("mem_wstrb", 32'(mem_if.mem_wstrb), 32'(m[35:32]));
          check("mem_wdata", mem_if.mem_wdata,      m[31:0]);
          check("stall_req", 32'(stall),            32'd1);
        end
        mem_if.mem_ack   = force_ack || (!no_ack && (req_cycles == ack_delay));
        mem_if.mem_rdata = resp_rdata;
        req_cycles++;
      end else begin
        if (prev_req && exp_mem_q.size() != 0) exp_mem_q.delete(0);
        mem_if.mem_ack = force_ack;
        req_cycles     = 0;
      end
      prev_req = mem_if.mem_req;
    end
  end

  // ---------------- completion monitor ----------------
  initial begin
    logic [32:0] e;
    int          el;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && (done === 1'b1 || err === 1'b1)) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_completion: got done=%b err=%b want none", done, err);
        end else begin
          e  = exp_q.pop_front();
          el = lat_q.pop_front();
          check("err_pulse",  32'(err),  32'(e[32]));
          check("done_pulse", 32'(done), 32'(!e[32]));
          check("rdata",      rdata,     e[31:0]);
          check("latency",    32'(cyc),  32'(el));
          check("stall_end",  32'(stall), 32'd0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_op(input logic [4:0] ld, input logic [2:0] st,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int delay, input logic [31:0] resp,
                       input logic exp_err, input logic exp_mem,
                       input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                       input logic [31:0] exp_rdata, input int exp_lat);
    @(posedge clk); #1;
    ack_delay  = delay;
    no_ack     = (delay < 0);
    resp_rdata = resp;
    Load = ld; Store = st; addr = a; wdata = wd;
    if (exp_mem) exp_mem_q.push_back({|st, {a[31:2], 2'b00}, exp_wstrb, exp_wdata});
    exp_q.push_back({exp_err, exp_rdata});
    lat_q.push_back(cyc + exp_lat);
    @(negedge clk);
    check("stall_sample", 32'(stall), 32'd1);
    @(posedge clk); #1;
    // Scramble the bus after sampling so the DUT must rely on its latched copy.
    Load = 5'd0; Store = 3'd0; addr = ~a; wdata = ~wd;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL completion_timeout: got no done/err want completion within 60 cycles");
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0; Load = 5'd0; Store = 3'd0; addr = 32'd0; wdata = 32'd0;
    #3;
    check("rst_mem_req",   32'(mem_if.mem_req),   32'd0);
    check("rst_mem_we",    32'(mem_if.mem_we),    32'd0);
    check("rst_mem_wstrb", 32'(mem_if.mem_wstrb), 32'd0);
    check("rst_mem_addr",  mem_if.mem_addr,       32'd0);
    check("rst_mem_wdata", mem_if.mem_wdata,      32'd0);
    check("rst_stall",     32'(stall),            32'd0);
    check("rst_done",      32'(done),             32'd0);
    check("rst_err",       32'(err),              32'd0);
    check("rst_rdata",     rdata,                 32'd0);
    check("rst_state",     32'(state_dbg),        32'(S_IDLE));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Stray ack while idle must not move the FSM.
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ack_state", 32'(state_dbg), 32'(S_IDLE));
    force_ack = 1'b0;

    //     Load      Store    addr          wdata         dly resp          err mem wstrb    mem_wdata     rdata         lat
    do_op(5'b00000, 3'b100, 32'h0000_0104, 32'hDEAD_BEEF, 1, 32'h0,         0, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0,         3);
    do_op(5'b00001, 3'b000, 32'h0000_0203, 32'h0,         0, 32'h80FF_FFFF, 0, 1, 4'b0000, 32'h0,         32'hFFFF_FF80, 2);
    do_op(5'b01000, 3'b000, 32'h0000_0203, 32'h0,         0, 32'h80FF_FFFF, 0, 1, 4'b0000, 32'h0,         32'h0000_0080, 2);
    do_op(5'b00000, 3'b010, 32'h0000_0102, 32'h0000_1234, 0, 32'h0,         0, 1, 4'b1100, 32'h1234_1234, 32'h0,         2);
    do_op(5'b00100, 3'b000, 32'h0000_0101, 32'h0,         0, 32'h0,         1, 0, 4'b0000, 32'h0,         32'h0,         1);
    do_op(5'b00101, 3'b000, 32'h0000_0100, 32'h0,         0, 32'h0,         1, 0, 4'b0000, 32'h0,         32'h0,         1);
    do_op(5'b00001, 3'b001, 32'h0000_0100, 32'h0,         0, 32'h0,         1, 0, 4'b0000, 32'h0,         32'h0,         1);
    do_op(5'b00000, 3'b011, 32'h0000_0100, 32'h0,         0, 32'h0,         1, 0, 4'b0000, 32'h0,         32'h0,         1);
    do_op(5'b00000, 3'b001, 32'h0000_0012, 32'h1122_33A5, 2, 32'h0,         0, 1, 4'b0100, 32'hA5A5_A5A5, 32'h0,         4);
    do_op(5'b00010, 3'b000, 32'h0000_0302, 32'h0,         0, 32'h8001_7FFF, 0, 1, 4'b0000, 32'h0,         32'hFFFF_8001, 2);
    do_op(5'b10000, 3'b000, 32'h0000_0300, 32'h0,         1, 32'h8001_F00D, 0, 1, 4'b0000, 32'h0,         32'h0000_F00D, 3);
    do_op(5'b00100, 3'b000, 32'h0000_0400, 32'h0,         0, 32'h1234_5678, 0, 1, 4'b0000, 32'h0,         32'h1234_5678, 2);
    do_op(5'b00001, 3'b000, 32'h0000_0201, 32'h0,         0, 32'h0000_7F00, 0, 1, 4'b0000, 32'h0,         32'h0000_007F, 2);
    do_op(5'b00010, 3'b000, 32'h0000_0300, 32'h0,         0, 32'h0000_8000, 0, 1, 4'b0000, 32'h0,         32'hFFFF_8000, 2);
    do_op(5'b00000, 3'b010, 32'h0000_0103, 32'h0,         0, 32'h0,         1, 0, 4'b0000, 32'h0,         32'h0,         1);
    do_op(5'b10000, 3'b000, 32'h0000_0301, 32'h0,         0, 32'h0,         1, 0, 4'b0000, 32'h0,         32'h0,         1);
    do_op(5'b00000, 3'b100, 32'h0000_0102, 32'h0,         0, 32'h0,         1, 0, 4'b0000, 32'h0,         32'h0,         1);
    do_op(5'b00000, 3'b010, 32'h0000_0100, 32'hCAFE_5678, 0, 32'h0,         0, 1, 4'b0011, 32'h5678_5678, 32'h0,         2);

`ifdef LSU_TIMEOUT_EN
    // Watchdog: 16 REQ cycles, err lands on N+17, a later ack is ignored.
    do_op(5'b00100, 3'b000, 32'h0000_0600, 32'h0,        -1, 32'h0,         1, 1, 4'b0000, 32'h0,         32'h0,         17);
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("late_ack_state", 32'(state_dbg), 32'(S_IDLE));
    force_ack = 1'b0;
`endif

    // Reset in the middle of REQ.
    @(posedge clk); #1;
    no_ack = 1'b1;
    Load = 5'b00100; Store = 3'd0; addr = 32'h0000_0500; wdata = 32'd0;
    exp_mem_q.push_back({1'b0, 32'h0000_0500, 4'b0000, 32'h0});
    @(posedge clk); #1;
    Load = 5'd0;
    @(negedge clk);
    check("rstreq_in_req", 32'(state_dbg), 32'(S_REQ));
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rstreq_mem_req", 32'(mem_if.mem_req), 32'd0);
    check("rstreq_stall",   32'(stall),          32'd0);
    check("rstreq_state",   32'(state_dbg),      32'(S_IDLE));
    @(posedge clk); #1 rst = 1'b1;
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("rstreq_after_state", 32'(state_dbg), 32'(S_IDLE));
    check("rstreq_after_done",  32'(done),      32'd0);
    force_ack = 1'b0;
    no_ack    = 1'b0;
    repeat (2) @(negedge clk);
    check("rstreq_mem_q_drained", 32'(exp_mem_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
